aes_dec_iter: RTL and testbench
===============================

AES_DEC_ITER -- requirements
Module: aes_dec_iter

Interface
REQ-001 SHALL have the ports below, in this order; clock and reset come first.
REQ-002 SHALL use one clock and reset; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ciphertext/key offer
- in_ready  out  1  core can accept an offer
- ct_in  in  128  ciphertext block; byte i = ct_in[8i+7:8i]; column c = bytes 4c..4c+3
- key_in  in  128  key, same byte order as ct_in (see REQ-020)
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts the plaintext
- pt_out  out  128  plaintext block, same byte order as ct_in
- busy  out  1  high in any state except IDLE

Function
REQ-003 SHALL implement the AES-128 inverse cipher per FIPS-197 (Nr=10), computing one inverse round per clock.
REQ-004 SHALL use an FSM with states IDLE, EXPAND, ROUND and DONE.
REQ-005 SHALL drive in_ready=1 only in IDLE; an offer is accepted on a cycle where in_valid&in_ready.
REQ-006 On acceptance, SHALL register ct_in and key_in and set the round counter.
- in_valid while busy is ignored, with no state change.
REQ-007 In EXPAND, SHALL run the forward key schedule one round key per cycle (RotWord, SubWord, Rcon 01..36), k1..k10, for exactly 10 cycles.
REQ-008 On the cycle k10 is produced, SHALL load state = ct ^ k10 and go to ROUND with r=10.
REQ-009 In ROUND with counter r (10 down to 1), each cycle SHALL:
- compute tmp = InvSubBytes(InvShiftRows(state)) ^ k(r-1);
- derive k(r-1) from k(r) with the inverse key schedule: w[i] ^= w[i-1] for words 3,2,1, then w0 ^= SubWord(RotWord(w3')) ^ Rcon(r);
- store InvMixColumns(tmp) if r>1, or tmp if r=1.
REQ-010 After the r=1 cycle, SHALL go to DONE with pt_out = final state and out_valid=1.
REQ-011 SHALL hold out_valid and pt_out stable until out_ready=1; on that cycle it SHALL go to IDLE.
- in_ready rises the following cycle; there is no overlap of transactions.
REQ-012 Latency: if acceptance is in cycle T, out_valid SHALL first be high in cycle T+21 (see REQ-020 for the other build), independent of out_ready.
REQ-013 out_ready asserted before out_valid SHALL have no effect.
REQ-014 SHALL do all GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1 (0x11b).
- InvMixColumns coefficients: 0e, 0b, 0d, 09, row-rotated per column.
REQ-015 pt_out SHALL read 0 in every state except DONE.

Reset
REQ-016 On rst=1, SHALL go to IDLE immediately (asynchronously) from any state, discarding the transaction in flight.
REQ-017 Reset values: in_ready=1 after release, out_valid=0, busy=0, pt_out=0; state, key and counter registers are 0.
REQ-018 The first acceptance after a mid-operation reset SHALL produce a correct result with the nominal latency.

Configuration
REQ-019 Without AES_DEC_LASTKEY_EN: key_in is the cipher key; the EXPAND state is used; latency is 21 cycles.
REQ-020 With AES_DEC_LASTKEY_EN defined:
- key_in is the round-10 key;
- EXPAND is never entered, and acceptance loads state = ct_in ^ key_in with r=10;
- out_valid is first high in cycle T+11;
- the forward key-schedule logic SHALL be removed.

Structure
REQ-021 Package aes_pkg SHALL hold:
- sbox and inverse sbox functions;
- Rcon table;
- xtime and general GF multiply functions;
- FSM state enum;
- constant NR=10.
REQ-022 SHALL put the combinational inverse round in one sub-module, aes_inv_round.
- Inputs: state, round key, last-round flag.
- Output: next state.

Verification
REQ-023 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff at T+21.
- With the macro, key_in = 13111d7fe3944a17f307a78b4d2b30c5 and the result appears at T+11.
REQ-024 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
- With the macro, key_in = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-025 Backpressure: out_ready=0 for 5 cycles after out_valid -> pt_out is held and in_ready stays 0; out_ready=1 -> IDLE and in_ready=1 on the next cycle.
REQ-026 Busy offers: in_valid held high with a different ct during ROUND -> ignored; the first result still matches C.1.
REQ-027 Reset mid-ROUND (r=5) -> out_valid=0, busy=0 and in_ready=1 after release; then run C.1 -> correct pt at nominal latency.
REQ-028 Back-to-back: in_valid tied high with C.1 then App. B and out_ready=1 -> two correct results, one cycle apart in IDLE.

Source files
------------

// File: rtl/aes_pkg.sv
//==============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 helpers: GF(2^8) arithmetic, S-boxes, Rcon,
//               word/column transforms and the decryption FSM state type.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package aes_pkg;

   localparam int NR = 10;

   localparam logic [7:0] RCON [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      ROUND  = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2, a3, a12, a15, a240;
      a2   = gf_mul(a, a);
      a3   = gf_mul(a2, a);
      a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
      a15  = gf_mul(a12, a3);
      a240 = gf_mul(a15, a15);
      a240 = gf_mul(a240, a240);
      a240 = gf_mul(a240, a240);
      a240 = gf_mul(a240, a240);
      return gf_mul(gf_mul(a240, a12), a2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      x = gf_inv(a);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
               ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] y;
      y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(y);
   endfunction

   // Words keep their first byte in the low bits, so RotWord is a right shift
   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[7:0], w[31:8]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[7:0];
      a1 = c[15:8];
      a2 = c[23:16];
      a3 = c[31:24];
      return {gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3),
              gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
              gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
              gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3)};
   endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_round.sv
//==============================================================================
// Module      : aes_inv_round
// Description : One combinational AES inverse round (InvShiftRows,
//               InvSubBytes, AddRoundKey, InvMixColumns unless last round).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         last_round,
   output logic [127:0] state_out
);

   logic [127:0] w_tmp;
   logic [127:0] w_mix;

   // Byte (row r, column c) of the result comes from column (c - r) mod 4
   always_comb begin
      w_tmp = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_tmp[8*(4*c+r) +: 8] = inv_sbox(state_in[8*(4*((c+4-r)%4)+r) +: 8])
                                    ^ round_key[8*(4*c+r) +: 8];
         end
      end
   end

   always_comb begin
      w_mix = '0;
      for (int c = 0; c < 4; c++) begin
         w_mix[32*c +: 32] = inv_mix_col(w_tmp[32*c +: 32]);
      end
   end

   assign state_out = last_round ? w_tmp : w_mix;

endmodule

`default_nettype wire

// File: rtl/aes_dec_iter.sv
//==============================================================================
// Module      : aes_dec_iter
// Description : Iterative AES-128 decryptor, one inverse round per clock.
//               Define AES_DEC_LASTKEY_EN to take the round-10 key directly
//               and drop the forward key schedule.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module aes_dec_iter
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ct_in,
   input  logic [127:0] key_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] pt_out,
   output logic         busy
);

   localparam logic [3:0] c_nr = 4'(NR);

   state_t       r_fsm;
   state_t       w_fsm_nxt;
   logic [127:0] r_key;
   logic [127:0] r_blk;
   logic [3:0]   r_cnt;
   logic [127:0] w_key_prev;
   logic [127:0] w_round_out;
   logic         w_accept;

   // Step the round key backwards: k(r) -> k(r-1)
   function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = k[127:96] ^ k[95:64];
      w2 = k[95:64]  ^ k[63:32];
      w1 = k[63:32]  ^ k[31:0];
      w0 = k[31:0]   ^ sub_word(rot_word(w3)) ^ {24'h0, rc};
      return {w3, w2, w1, w0};
   endfunction

`ifndef AES_DEC_LASTKEY_EN
   logic [127:0] r_ct;
   logic [127:0] w_key_next;

   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[31:0]   ^ sub_word(rot_word(k[127:96])) ^ {24'h0, rc};
      w1 = k[63:32]  ^ w0;
      w2 = k[95:64]  ^ w1;
      w3 = k[127:96] ^ w2;
      return {w3, w2, w1, w0};
   endfunction

   assign w_key_next = key_fwd(r_key, RCON[r_cnt]);
`endif

   assign w_key_prev = key_inv(r_key, RCON[r_cnt]);
   assign w_accept   = (r_fsm == IDLE) && in_valid;

   aes_inv_round u_inv_round (
      .state_in   (r_blk),
      .round_key  (w_key_prev),
      .last_round (r_cnt == 4'd1),
      .state_out  (w_round_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_fsm <= IDLE;
      else     r_fsm <= w_fsm_nxt;
   end

   always_comb begin
      w_fsm_nxt = r_fsm;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      pt_out    = '0;
      case (r_fsm)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
`ifdef AES_DEC_LASTKEY_EN
            if (in_valid) w_fsm_nxt = ROUND;
`else
            if (in_valid) w_fsm_nxt = EXPAND;
`endif
         end
         EXPAND:  if (r_cnt == c_nr) w_fsm_nxt = ROUND;
         ROUND:   if (r_cnt == 4'd1) w_fsm_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            pt_out    = r_blk;
            if (out_ready) w_fsm_nxt = IDLE;
         end
         default: w_fsm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_key <= '0;
         r_blk <= '0;
         r_cnt <= '0;
`ifndef AES_DEC_LASTKEY_EN
         r_ct  <= '0;
`endif
      end else begin
         case (r_fsm)
            IDLE: begin
               if (w_accept) begin
                  r_key <= key_in;
`ifdef AES_DEC_LASTKEY_EN
                  r_blk <= ct_in ^ key_in;
                  r_cnt <= c_nr;
`else
                  r_ct  <= ct_in;
                  r_cnt <= 4'd1;
`endif
               end
            end
`ifndef AES_DEC_LASTKEY_EN
            EXPAND: begin
               // r_cnt counts up to 10 and then doubles as the first round index
               r_key <= w_key_next;
               if (r_cnt == c_nr) r_blk <= r_ct ^ w_key_next;
               else               r_cnt <= r_cnt + 4'd1;
            end
`endif
            ROUND: begin
               r_blk <= w_round_out;
               r_key <= w_key_prev;
               r_cnt <= r_cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_aes_dec_iter.sv
//==============================================================================
// Module      : tb_aes_dec_iter
// Description : Scoreboard testbench for aes_dec_iter using FIPS-197 vectors.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_aes_dec_iter;

`ifdef AES_DEC_LASTKEY_EN
   localparam int           LAT  = 11;
   localparam logic [127:0] K_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] K_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`else
   localparam int           LAT  = 21;
   localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`endif
   localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam int           BUDGET = 200;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ct_in;
   logic [127:0] key_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] pt_out;
   logic         busy;

   logic [127:0] q_exp[$];
   int           n_cmp;
   int           n_fail;

   aes_dec_iter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ct_in     (ct_in),
      .key_in    (key_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt_out    (pt_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIPS hex strings list byte 0 first; the ports carry byte 0 in the low bits
   function automatic logic [127:0] bs(input logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [127:0] ct, input logic [127:0] key,
                        input logic [127:0] pt, input bit keep);
      ct_in    = bs(ct);
      key_in   = bs(key);
      in_valid = 1'b1;
      q_exp.push_back(bs(pt));
      tick();
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 1;
      while (!out_valid && cyc < BUDGET) begin
         tick();
         cyc++;
      end
   endtask

   function automatic logic [127:0] pop_exp();
      if (q_exp.size() == 0) return 'x;
      return q_exp.pop_front();
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ct_in = '0; key_in = '0;
      repeat (3) tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_cmp++; if (pt_out !== '0) begin n_fail++; $display("FAIL rst_pt_out: got %h expected 0", pt_out); end
      rst = 1'b0;
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b expected 1", in_ready); end
      n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_idle: got busy=%b out_valid=%b expected 0/0", busy, out_valid); end
   endtask

   task automatic test_fips_c1();
      int cyc;
      logic [127:0] exp_pt;
      offer(CT_C1, K_C1, PT_C1, 1'b0);
      n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL c1_busy: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
      wait_valid(cyc);
      exp_pt = pop_exp();
      n_cmp++; if (cyc != LAT) begin n_fail++; $display("FAIL c1_latency: got %0d expected %0d", cyc, LAT); end
      n_cmp++; if (pt_out !== exp_pt) begin n_fail++; $display("FAIL c1_pt: got %h expected %h", pt_out, exp_pt); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || pt_out !== '0) begin n_fail++; $display("FAIL c1_release: got in_ready=%b out_valid=%b pt=%h expected 1/0/0", in_ready, out_valid, pt_out); end
   endtask

   task automatic test_fips_b_early_ready();
      int cyc;
      logic [127:0] exp_pt;
      out_ready = 1'b1;
      offer(CT_B, K_B, PT_B, 1'b0);
      wait_valid(cyc);
      exp_pt = pop_exp();
      n_cmp++; if (cyc != LAT) begin n_fail++; $display("FAIL b_latency: got %0d expected %0d", cyc, LAT); end
      n_cmp++; if (pt_out !== exp_pt) begin n_fail++; $display("FAIL b_pt: got %h expected %h", pt_out, exp_pt); end
      tick();
      out_ready = 1'b0;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [127:0] exp_pt;
      offer(CT_C1, K_C1, PT_C1, 1'b0);
      wait_valid(cyc);
      exp_pt = pop_exp();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (pt_out !== exp_pt || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got pt=%h ov=%b ir=%b expected pt=%h ov=1 ir=0", i, pt_out, out_valid, in_ready, exp_pt);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
   endtask

   task automatic test_busy_offers();
      int cyc;
      bit bad;
      logic [127:0] exp_pt;
      bad = 1'b0;
      offer(CT_C1, K_C1, PT_C1, 1'b1);
      ct_in = bs(CT_B);
      cyc = 1;
      while (!out_valid && cyc < BUDGET) begin
         if (in_ready !== 1'b0 || pt_out !== '0) bad = 1'b1;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      exp_pt = pop_exp();
      n_cmp++; if (bad) begin n_fail++; $display("FAIL busy_ignore: got in_ready/pt_out active while busy expected in_ready=0 pt_out=0"); end
      n_cmp++; if (cyc != LAT) begin n_fail++; $display("FAIL busy_latency: got %0d expected %0d", cyc, LAT); end
      n_cmp++; if (pt_out !== exp_pt) begin n_fail++; $display("FAIL busy_pt: got %h expected %h", pt_out, exp_pt); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int cyc;
      logic [127:0] exp_pt;
      offer(CT_C1, K_C1, PT_C1, 1'b0);
      repeat (LAT - 6) tick();
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
      #2 rst = 1'b1;
      #1;
      q_exp.delete();
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_async: got out_valid=%b busy=%b expected 0/0", out_valid, busy); end
      tick();
      rst = 1'b0;
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
      offer(CT_C1, K_C1, PT_C1, 1'b0);
      wait_valid(cyc);
      exp_pt = pop_exp();
      n_cmp++; if (cyc != LAT) begin n_fail++; $display("FAIL mid_latency: got %0d expected %0d", cyc, LAT); end
      n_cmp++; if (pt_out !== exp_pt) begin n_fail++; $display("FAIL mid_pt: got %h expected %h", pt_out, exp_pt); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n_acc;
      int n_out;
      int out_t[2];
      bit acc_now;
      logic [127:0] exp_pt;
      n_acc = 0;
      n_out = 0;
      out_t[0] = 0;
      out_t[1] = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      ct_in     = bs(CT_C1);
      key_in    = bs(K_C1);
      for (int cyc = 0; cyc < 2 * BUDGET && n_out < 2; cyc++) begin
         if (out_valid) begin
            exp_pt = pop_exp();
            n_cmp++; if (pt_out !== exp_pt) begin n_fail++; $display("FAIL b2b_pt[%0d]: got %h expected %h", n_out, pt_out, exp_pt); end
            out_t[n_out] = cyc;
            n_out++;
         end
         acc_now = in_ready && in_valid;
         if (acc_now) q_exp.push_back(n_acc == 0 ? bs(PT_C1) : bs(PT_B));
         tick();
         if (acc_now) begin
            n_acc++;
            if (n_acc == 1) begin
               ct_in  = bs(CT_B);
               key_in = bs(K_B);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_cmp++; if (n_out != 2) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 2", n_out); end
      n_cmp++; if (out_t[1] - out_t[0] != LAT + 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles expected %0d", out_t[1] - out_t[0], LAT + 1); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_fips_c1();
      test_fips_b_early_ready();
      test_backpressure();
      test_busy_offers();
      test_reset_mid();
      test_back_to_back();
      n_cmp++; if (q_exp.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", q_exp.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
